// File: rtl/mem_arbiter.sv
// Two-port req/gnt arbiter sharing a single-ported word memory between
// instruction fetch and load/store, with data priority and fetch anti-starvation.
module mem_arbiter #(
  parameter int MEM_SIZE     = 1024,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] m_base,
  output logic [31:0] m_offset,
  output logic        m_r_enabled,
  output logic        m_w_enabled,
  output logic [31:0] m_w_data,
  input  logic [31:0] m_r_data
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             own_fetch;
  logic             we_q;
  logic             err_q;
  logic             fetch_win;
  logic             data_win;
  logic             d_addr_err;
  logic             in_access;
  logic             if_accept;
  logic             d_accept;

  // Grants and memory enables are qualified by rstn so a reset edge can
  // neither accept a request nor commit a write.
  always_comb begin
    fetch_win  = if_req & (~d_req | (starve_cnt == CNT_MAX));
    data_win   = d_req & ~fetch_win;
    if_gnt     = rstn & (state == IDLE) & fetch_win;
    d_gnt      = rstn & (state == IDLE) & data_win;
    if_accept  = if_req & if_gnt;
    d_accept   = d_req & d_gnt;
    d_addr_err = (d_addr[1:0] != 2'b00) | ({2'b00, d_addr[31:2]} >= 32'(MEM_SIZE));
    in_access  = rstn & (state == ACCESS);
  end

  assign m_offset    = 32'h0;
  assign m_r_enabled = in_access & ~we_q & ~err_q;
  assign m_w_enabled = in_access & we_q & ~err_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      starve_cnt <= '0;
      own_fetch  <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      m_base     <= 32'h0;
      m_w_data   <= 32'h0;
      if_rvalid  <= 1'b0;
      if_rdata   <= 32'h0;
      d_rvalid   <= 1'b0;
      d_rdata    <= 32'h0;
      d_err      <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      d_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (if_accept) begin
            own_fetch  <= 1'b1;
            m_base     <= if_addr;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            starve_cnt <= '0;
            state      <= ACCESS;
          end else if (d_accept) begin
            own_fetch <= 1'b0;
            m_base    <= d_addr;
            we_q      <= d_we;
            m_w_data  <= d_wdata;
            err_q     <= d_addr_err;
            state     <= ACCESS;
            // Fetch lost this opportunity; count it toward a forced grant.
            if (if_req && (starve_cnt != CNT_MAX))
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        ACCESS: begin
          if (own_fetch) begin
            if_rvalid <= 1'b1;
            if_rdata  <= m_r_data;
          end else begin
            d_rvalid <= 1'b1;
            d_rdata  <= (we_q | err_q) ? 32'h0 : m_r_data;
            d_err    <= err_q;
          end
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus scoreboard of
// expected responses, with hand-written starvation and reset-abort sequences.
module tb_mem_arbiter;

  localparam int MEM_SIZE     = 1024;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] m_base;
  logic [31:0] m_offset;
  logic        m_r_enabled;
  logic        m_w_enabled;
  logic [31:0] m_w_data;
  logic [31:0] m_r_data;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
    logic        err;
    int          cycle;
  } exp_t;

  vec_t        vecs[16];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        mem_clear;
  logic [31:0] mem [0:MEM_SIZE-1];

  mem_arbiter #(.MEM_SIZE(MEM_SIZE), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_base(m_base), .m_offset(m_offset), .m_r_enabled(m_r_enabled),
    .m_w_enabled(m_w_enabled), .m_w_data(m_w_data), .m_r_data(m_r_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-ported memory: combinational read, write at clock edge.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= 32'h0;
      mem[MEM_SIZE-1] <= 32'hCAFEF00D;
    end else if (m_w_enabled) begin
      mem[m_base[11:2]] <= m_w_data;
    end
  end
  assign m_r_data = (m_base[31:12] == 20'h0) ? mem[m_base[11:2]] : 32'h0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushExpect(input logic port, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.port  = port;
    e.rdata = rdata;
    e.err   = err;
    e.cycle = cyc + 1;
    sb.push_back(e);
  endtask

  // Raise one request, wait (bounded) for its grant, record the expected response.
  task automatic applyStimulus(input vec_t v);
    int  tries = 0;
    bit  done  = 0;
    @(negedge clk);
    if (v.port) begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end else begin
      d_req   = 1'b1;
      d_we    = v.we;
      d_addr  = v.addr;
      d_wdata = v.wdata;
    end
    while (!done && tries < 20) begin
      #1;
      if ((v.port && if_gnt) || (!v.port && d_gnt)) begin
        @(posedge clk);
        #1;
        pushExpect(v.port, v.exp_rdata, v.exp_err);
        if_req = 1'b0;
        d_req  = 1'b0;
        done   = 1;
      end else begin
        @(negedge clk);
        tries++;
      end
    end
    if (!done) begin
      checkOutput("grant timeout", 32'h0, 32'h1);
      if_req = 1'b0;
      d_req  = 1'b0;
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while (sb.size() > 0 && n < 30) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (sb.size() > 0) begin
      checkOutput("response timeout", sb.size(), 32'h0);
      sb.delete();
    end
  endtask

  // Response monitor: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (if_rvalid || d_rvalid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected rvalid", {30'h0, if_rvalid, d_rvalid}, 32'h0);
      end else begin
        e = sb.pop_front();
        checkOutput("single rvalid", {31'h0, if_rvalid & d_rvalid}, 32'h0);
        checkOutput("rvalid port", {31'h0, if_rvalid}, {31'h0, e.port});
        checkOutput("rdata", e.port ? if_rdata : d_rdata, e.rdata);
        checkOutput("d_err", {31'h0, d_err}, e.port ? 32'h0 : {31'h0, e.err});
        checkOutput("latency", cyc, e.cycle);
      end
    end
    if (if_gnt && d_gnt) checkOutput("dual grant", 32'h1, 32'h0);
    if (m_w_enabled)
      checkOutput("write addr legal",
                  {31'h0, (m_base[1:0] == 2'b00) && (m_base[31:12] == 20'h0)}, 32'h1);
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish (checks %0d)", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'h0000000C, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0000000C, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h00000010, 32'h00000013, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h00000010, 32'h0,        32'h00000013, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h00000002, 32'h12345678, 32'h00000000, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 32'h00001000, 32'h0,        32'h00000000, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'h00001000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 32'h00000020, 32'h55AA55AA, 32'h00000000, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h00000020, 32'h0,        32'h55AA55AA, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000000C, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 32'h00000FFC, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h00001001, 32'h0,        32'h00000000, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 32'h00000000, 32'h0,        32'h00000000, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 32'h0000000C, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 32'h00000040, 32'h0,        32'h00000000, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 32'h00000FFC, 32'h0,        32'hCAFEF00D, 1'b0};

    rstn = 1'b0; mem_clear = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset if_gnt", {31'h0, if_gnt}, 32'h0);
    checkOutput("reset d_gnt", {31'h0, d_gnt}, 32'h0);
    checkOutput("reset if_rvalid", {31'h0, if_rvalid}, 32'h0);
    checkOutput("reset d_rvalid", {31'h0, d_rvalid}, 32'h0);
    checkOutput("reset d_err", {31'h0, d_err}, 32'h0);
    checkOutput("reset enables", {30'h0, m_r_enabled, m_w_enabled}, 32'h0);
    checkOutput("reset if_rdata", if_rdata, 32'h0);
    checkOutput("reset d_rdata", d_rdata, 32'h0);
    checkOutput("reset m_base", m_base, 32'h0);
    checkOutput("reset m_w_data", m_w_data, 32'h0);
    checkOutput("m_offset", m_offset, 32'h0);
    rstn = 1'b1; mem_clear = 1'b0;

    // Requests are issued back to back, so vector 8 is accepted in the cycle
    // that shows vector 7's completion.
    for (int i = 0; i < 13; i++) applyStimulus(vecs[i]);
    waitIdle();
    checkOutput("mem[0] untouched", mem[0], 32'h0);
    checkOutput("mem[3] stored", mem[3], 32'hDEADBEEF);

    // Both ports held: expect DDDDF repeating.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
    for (int i = 0; i < 15; i++) begin
      #1;
      checkOutput("starve if_gnt", {31'h0, if_gnt}, {31'h0, (i % 5) == 4});
      checkOutput("starve d_gnt", {31'h0, d_gnt}, {31'h0, (i % 5) != 4});
      @(posedge clk);
      #1;
      if ((i % 5) == 4) pushExpect(1'b1, 32'h00000013, 1'b0);
      else              pushExpect(1'b0, 32'h00000000, 1'b0);
      @(negedge clk);
      #1;
      checkOutput("access no gnt", {30'h0, if_gnt, d_gnt}, 32'h0);
      @(negedge clk);
    end
    if_req = 1'b0; d_req = 1'b0;
    waitIdle();

    // Reset asserted during the ACCESS cycle of a store to 0x40.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1;
    #1;
    checkOutput("abort d_gnt", {31'h0, d_gnt}, 32'h1);
    @(posedge clk);
    #1;
    d_req = 1'b0; rstn = 1'b0;
    #1;
    checkOutput("abort m_w_enabled", {31'h0, m_w_enabled}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort d_rvalid", {31'h0, d_rvalid}, 32'h0);
    checkOutput("abort m_base", m_base, 32'h0);
    checkOutput("abort m_w_data", m_w_data, 32'h0);
    checkOutput("abort d_rdata", d_rdata, 32'h0);
    checkOutput("abort if_rdata", if_rdata, 32'h0);
    checkOutput("abort mem[16]", mem[16], 32'h0);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("post-abort d_rvalid", {31'h0, d_rvalid}, 32'h0);

    for (int i = 13; i < 16; i++) applyStimulus(vecs[i]);
    waitIdle();
    checkOutput("mem[16] final", mem[16], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-ported word memory between the instruction-fetch stage and the load/store stage. Both requesters use a req/gnt handshake; the arbiter latches the winning request, drives the memory for exactly one access cycle, and returns registered read data with a one-cycle valid pulse. Data accesses win by default. A starvation counter forces a fetch grant after a bounded wait. Misaligned and out-of-range data accesses are rejected with an error response and never reach the memory.

## Interface
- MEM_SIZE, 1024: memory depth in 32-bit words; bounds-check limit.
- STARVE_LIMIT, 4: consecutive lost arbitration cycles after which fetch wins (≥1).
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- if_req  in  1  fetch request; held with if_addr stable until accepted.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch accepted this cycle (accept = if_req & if_gnt at rising edge).
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  32  fetched word.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until accepted.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  data accepted this cycle.
- d_rvalid  out  1  one-cycle completion pulse (loads and stores).
- d_rdata  out  32  load data; 0 for stores and errors.
- d_err  out  1  coincident with d_rvalid; access was rejected.
- m_base  out  32  memory base (latched byte address).
- m_offset  out  32  memory offset, constant 0.
- m_r_enabled  out  1  memory read enable.
- m_w_enabled  out  1  memory write enable.
- m_w_data  out  32  memory write data.
- m_r_data  in  32  memory read data (combinational from memory).

## Operation
- FSM: IDLE, ACCESS. Reset → IDLE.
- IDLE: grant is combinational from state, requests and the starvation counter.
  - fetch wins if if_req & (!d_req | starve_cnt == STARVE_LIMIT); otherwise data wins if d_req.
  - Only the winner's gnt is high; at most one gnt per cycle.
  - On accept: latch port id, address, we, wdata, and err. Go to ACCESS.
- starve_cnt, width $clog2(STARVE_LIMIT+1):
  - increments (saturating at STARVE_LIMIT) in IDLE when if_req & d_gnt;
  - clears on fetch accept;
  - holds otherwise.
- err is computed at accept, for the data port only: addr[1:0] != 0, or unsigned addr[31:2] ≥ MEM_SIZE. Fetch is never checked.
- ACCESS (exactly one cycle):
  - m_base = latched address; m_offset = 0.
  - m_r_enabled = !we & !err; m_w_enabled = we & !err; m_w_data = latched wdata.
  - At the end of ACCESS: capture rdata (m_r_data for a load or fetch, else 0) and err into output registers, pulse the owner's rvalid, return to IDLE.
- All m_* enables are 0 outside ACCESS. m_base and m_w_data hold their last value.
- gnt is 0 in ACCESS; requesters keep waiting.

## Timing
- Accept at edge k → ACCESS during cycle k..k+1 → rvalid/rdata high during cycle k+1..k+2.
- Peak throughput: one access per 2 cycles. A new accept may occur in the same IDLE cycle that shows rvalid of the previous access.
- A store's memory write commits at the edge ending ACCESS. A load accepted immediately after it reads the new value.
- Both requesting with starve_cnt < STARVE_LIMIT: d_gnt. With starve_cnt == STARVE_LIMIT: if_gnt.
- Error access: still occupies ACCESS with both enables 0; d_rvalid = d_err = 1, d_rdata = 0.
- Reset values (rstn low at an edge):
  - state IDLE, starve_cnt 0;
  - all gnt, rvalid, d_err, m_r_enabled, m_w_enabled = 0;
  - rdata regs, m_base, m_w_data = 0.
- Reset during ACCESS aborts the access: no write commits at that edge and no rvalid follows.

## Test plan
- Single load: write mem[3]=0xDEADBEEF via store to d_addr=0x0C; then load 0x0C → d_gnt at accept, d_rvalid 2 cycles later, d_rdata=0xDEADBEEF, d_err=0.
- Fetch only: if_req with if_addr=0x10, mem[4]=0x00000013 → if_gnt same cycle, if_rvalid 2 cycles later, if_rdata=0x00000013, no d_* activity.
- Contention/starvation with STARVE_LIMIT=4: both requests held continuously → 4 data accepts, then 1 fetch accept, pattern repeats. Fetch never waits more than 4 grant opportunities.
- Misaligned and out-of-range data: d_addr=0x0000_0002, then d_addr=4*MEM_SIZE → each gives d_rvalid=1, d_err=1, d_rdata=0, m_w_enabled never high, memory unchanged.
- Store-then-load back-to-back: store 0x55AA55AA to 0x20 and immediately load 0x20 → load returns 0x55AA55AA. Store pulses d_rvalid with d_rdata=0.
- Reset mid-access: rstn low in the ACCESS cycle of a store of 0x1 to 0x40 → no d_rvalid, mem[16] unchanged, all outputs 0 next cycle, normal operation after rstn high.
